// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - digit codes, controller state encoding and BCD-to-segment decode
package seg_pkg;

    localparam logic SEG_DIG_ON = 1'b0;

    // {digit enable (active low), dp, g..a}
    localparam logic [8:0] SEG_D0 = {SEG_DIG_ON, 8'h3F};
    localparam logic [8:0] SEG_D1 = {SEG_DIG_ON, 8'h06};
    localparam logic [8:0] SEG_D2 = {SEG_DIG_ON, 8'h5B};
    localparam logic [8:0] SEG_D3 = {SEG_DIG_ON, 8'h4F};
    localparam logic [8:0] SEG_D4 = {SEG_DIG_ON, 8'h66};
    localparam logic [8:0] SEG_D5 = {SEG_DIG_ON, 8'h6D};
    localparam logic [8:0] SEG_D6 = {SEG_DIG_ON, 8'h7D};
    localparam logic [8:0] SEG_D7 = {SEG_DIG_ON, 8'h07};
    localparam logic [8:0] SEG_D8 = {SEG_DIG_ON, 8'h7F};
    localparam logic [8:0] SEG_D9 = {SEG_DIG_ON, 8'h6F};

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [8:0] bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_D0;
            4'd1:    return SEG_D1;
            4'd2:    return SEG_D2;
            4'd3:    return SEG_D3;
            4'd4:    return SEG_D4;
            4'd5:    return SEG_D5;
            4'd6:    return SEG_D6;
            4'd7:    return SEG_D7;
            4'd8:    return SEG_D8;
            4'd9:    return SEG_D9;
            default: return 9'h000;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer plus stability counter for one active-low push button
module key_debounce #(
    parameter int DB_CYCLES = 240_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q counts mismatching cycles already seen; the DB_CYCLES-th one flips the level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level   = level_q;
    assign press_pulse = level_q & ~level_d;

endmodule

// File: rtl/seg_counter_ctrl.sv
// rtl/seg_counter_ctrl.sv - 00-99 BCD run/stop counter driving two 9-bit segment digits
module seg_counter_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 12_000_000,
    parameter int DB_CYCLES = 240_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_run,
    input  logic       key_clr,
    input  logic       up_down,
    output logic [8:0] segment_led_1,
    output logic [8:0] segment_led_2,
    output logic       running
);

    localparam int TW = $clog2(TICK_DIV + 1);

    state_e        state_q;
    logic [3:0]    tens_q;
    logic [3:0]    units_q;
    logic [3:0]    tens_d;
    logic [3:0]    units_d;
    logic [TW-1:0] tick_q;
    logic          tick;
    logic [8:0]    seg1_q;
    logic [8:0]    seg2_q;
    logic          running_q;
    logic          run_press;
    logic          clr_press;
    logic          run_level_unused;
    logic          clr_level_unused;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_run),
        .key_level   (run_level_unused),
        .press_pulse (run_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_clr),
        .key_level   (clr_level_unused),
        .press_pulse (clr_press)
    );

    assign tick = (state_q == RUN) && (tick_q == TW'(TICK_DIV - 1));

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (!up_down) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end else begin
            if (units_q == 4'd0) begin
                units_d = 4'd9;
                tens_d  = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            end else begin
                units_d = units_q - 4'd1;
            end
        end
    end

    // Clear outranks a run toggle, and a run toggle swallows a coincident tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STOP;
            tens_q    <= 4'd0;
            units_q   <= 4'd0;
            tick_q    <= '0;
            seg1_q    <= SEG_D0;
            seg2_q    <= SEG_D0;
            running_q <= 1'b0;
        end else begin
            seg1_q    <= bcd_to_seg(tens_q);
            seg2_q    <= bcd_to_seg(units_q);
            running_q <= (state_q == RUN);
            if (clr_press) begin
                state_q <= STOP;
                tens_q  <= 4'd0;
                units_q <= 4'd0;
                tick_q  <= '0;
            end else if (run_press) begin
                state_q <= (state_q == RUN) ? STOP : RUN;
                tick_q  <= '0;
            end else if (state_q == RUN) begin
                if (tick) begin
                    tick_q  <= '0;
                    tens_q  <= tens_d;
                    units_q <= units_d;
                end else begin
                    tick_q <= tick_q + 1'b1;
                end
            end else begin
                tick_q <= '0;
            end
        end
    end

    assign segment_led_1 = seg1_q;
    assign segment_led_2 = seg2_q;
    assign running       = running_q;

endmodule

// File: tb/tb_seg_counter_ctrl.sv
// tb/tb_seg_counter_ctrl.sv - randomized bench for seg_counter_ctrl against a decimal counter model
module tb_seg_counter_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int DB_CYCLES = 4;
    localparam int LAT       = DB_CYCLES + 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       key_run = 1'b1;
    logic       key_clr = 1'b1;
    logic       up_down = 1'b0;
    logic [8:0] segment_led_1;
    logic [8:0] segment_led_2;
    logic       running;

    seg_counter_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_run       (key_run),
        .key_clr       (key_clr),
        .up_down       (up_down),
        .segment_led_1 (segment_led_1),
        .segment_led_2 (segment_led_2),
        .running       (running)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          m_count;
    int          m_phase;
    int          m_entry;
    bit          m_run;
    bit          run_ev;
    bit          clr_ev;
    logic [18:0] exp_out;
    int          run_q[$];
    int          clr_q[$];
    wire  [18:0] dut_out = {segment_led_1, segment_led_2, running};

    function automatic logic [8:0] ref_seg(input int d);
        case (d)
            0: return 9'h03F;  1: return 9'h006;  2: return 9'h05B;  3: return 9'h04F;
            4: return 9'h066;  5: return 9'h06D;  6: return 9'h07D;  7: return 9'h007;
            8: return 9'h07F;  9: return 9'h06F;
            default: return 9'h1FF;
        endcase
    endfunction

    function automatic logic [18:0] ref_out(input int cnt, input bit run);
        return {ref_seg(cnt / 10), ref_seg(cnt % 10), run};
    endfunction

    // Counter model: presses land a fixed latency after the key is driven low
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count = 0;
            m_run   = 1'b0;
            m_phase = 0;
            exp_out = ref_out(0, 1'b0);
            run_q.delete();
            clr_q.delete();
        end else begin
            cyc++;
            exp_out = ref_out(m_count, m_run);
            run_ev  = 1'b0;
            clr_ev  = 1'b0;
            if (clr_q.size() > 0 && clr_q[0] == cyc) begin clr_ev = 1'b1; void'(clr_q.pop_front()); end
            if (run_q.size() > 0 && run_q[0] == cyc) begin run_ev = 1'b1; void'(run_q.pop_front()); end
            if (clr_ev) begin
                m_count = 0;
                m_run   = 1'b0;
                m_phase = 0;
            end else if (run_ev) begin
                m_run   = !m_run;
                m_phase = 0;
                m_entry = cyc;
            end else if (m_run) begin
                m_phase++;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_count = up_down ? (m_count + 99) % 100 : (m_count + 1) % 100;
                end
            end
        end
    end

    task automatic press_keys(input bit do_run, input bit do_clr);
        if (do_run) begin key_run = 1'b0; run_q.push_back(cyc + LAT); end
        if (do_clr) begin key_clr = 1'b0; clr_q.push_back(cyc + LAT); end
    endtask

    task automatic advance_to(input int t);
        for (int i = 0; i < 1000 && cyc < t; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int next_tick(input int from);
        return m_entry + TICK_DIV * ((from - m_entry + TICK_DIV - 1) / TICK_DIV);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut_out !== {9'h03F, 9'h03F, 1'b0}) begin
            n_bad++; $display("FAIL reset_state got=%h exp=%h", dut_out, {9'h03F, 9'h03F, 1'b0});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
    endtask

    task automatic test_run_up();
        up_down = 1'b0;
        @(posedge clk); #1;
        press_keys(1'b1, 1'b0);
        for (int i = 1; i <= LAT + 1 + TICK_DIV * 10; i++) begin
            @(posedge clk); #1;
            if (i == 10) key_run = 1'b1;
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL run_up cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
            if (i == 7) begin
                n_cmp++;
                if (running !== 1'b1) begin n_bad++; $display("FAIL run_start got=%b exp=1", running); end
            end
        end
        n_cmp++;
        if (dut_out[18:1] !== {9'h006, 9'h03F}) begin
            n_bad++; $display("FAIL ten_ticks got=%h exp=%h", dut_out[18:1], {9'h006, 9'h03F});
        end
    endtask

    task automatic test_up_wrap();
        for (int w = 0; w < 3; w++) begin
            int target;
            int i;
            target = (w == 0) ? 99 : w - 1;
            for (i = 0; i < 1200 && m_count != target; i++) begin
                @(negedge clk); n_cmp++;
                if (dut_out !== exp_out) begin n_bad++; $display("FAIL up_wrap cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
            end
            @(negedge clk); n_cmp++;
            if (dut_out !== ref_out(target, 1'b1) || i >= 1200) begin
                n_bad++; $display("FAIL up_wrap_%0d got=%h exp=%h", target, dut_out, ref_out(target, 1'b1));
            end
        end
    endtask

    task automatic test_down_wrap();
        int i;
        @(posedge clk); #1;
        up_down = 1'b1;
        for (i = 0; i < 60 && m_count != 99; i++) begin
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL down_wrap cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
        @(negedge clk); n_cmp++;
        if (dut_out !== {9'h06F, 9'h06F, 1'b1} || i >= 60) begin
            n_bad++; $display("FAIL down_wrap_99 got=%h exp=%h", dut_out, {9'h06F, 9'h06F, 1'b1});
        end
        for (int j = 0; j < 300; j++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 6) == 0) up_down = ~up_down;
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL dir_toggle cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
    endtask

    task automatic test_bounce();
        int left;
        int lo;
        int hi;
        bit r;
        left = 40;
        r    = m_run;
        while (left > 0) begin
            lo = int'($urandom_range(1, 3));
            hi = int'($urandom_range(1, 3));
            for (int j = 0; j < lo + hi; j++) begin
                @(posedge clk); #1;
                key_run = (j >= lo);
                @(negedge clk); n_cmp++;
                if (dut_out !== exp_out) begin n_bad++; $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
            end
            left -= lo + hi;
        end
        n_cmp++;
        if (running !== r) begin n_bad++; $display("FAIL bounce_hold got=%b exp=%b", running, r); end
        repeat (3) @(posedge clk);
        #1;
        press_keys(1'b1, 1'b0);
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            if (j == 10) key_run = 1'b1;
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL solid_press cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
        n_cmp++;
        if (running !== !r) begin n_bad++; $display("FAIL solid_toggle got=%b exp=%b", running, !r); end
    endtask

    task automatic test_clear_tick();
        int t;
        int c0;
        int e;
        up_down = 1'b0;
        if (!m_run) begin
            @(posedge clk); #1;
            press_keys(1'b1, 1'b0);
            for (int i = 1; i <= 16; i++) begin
                @(posedge clk); #1;
                if (i == 10) key_run = 1'b1;
                @(negedge clk); n_cmp++;
                if (dut_out !== exp_out) begin n_bad++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
            end
        end
        t = next_tick(cyc + LAT + 1);
        advance_to(t - LAT);
        c0 = m_count;
        press_keys(1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 10) key_run = 1'b1;
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL stop_on_tick cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
        n_cmp++;
        if (dut_out !== ref_out(c0, 1'b0)) begin n_bad++; $display("FAIL stop_discard got=%h exp=%h", dut_out, ref_out(c0, 1'b0)); end

        press_keys(1'b1, 1'b0);
        e = cyc + LAT;
        for (int i = 1; i <= LAT + TICK_DIV + 2; i++) begin
            @(posedge clk); #1;
            if (i == 10) key_run = 1'b1;
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL rerun cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
            if (cyc == e + TICK_DIV) begin
                n_cmp++;
                if (dut_out !== ref_out(c0, 1'b1)) begin n_bad++; $display("FAIL first_step_early got=%h exp=%h", dut_out, ref_out(c0, 1'b1)); end
            end
            if (cyc == e + TICK_DIV + 1) begin
                n_cmp++;
                if (dut_out !== ref_out((c0 + 1) % 100, 1'b1)) begin
                    n_bad++; $display("FAIL first_step got=%h exp=%h", dut_out, ref_out((c0 + 1) % 100, 1'b1));
                end
            end
        end

        t = next_tick(cyc + LAT + 1);
        advance_to(t - LAT);
        press_keys(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 10) begin key_run = 1'b1; key_clr = 1'b1; end
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL clr_on_tick cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
        n_cmp++;
        if (dut_out !== {9'h03F, 9'h03F, 1'b0}) begin
            n_bad++; $display("FAIL clr_wins got=%h exp=%h", dut_out, {9'h03F, 9'h03F, 1'b0});
        end
    endtask

    task automatic test_reset_midrun();
        @(posedge clk); #1;
        press_keys(1'b1, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (i == 10) key_run = 1'b1;
            if (i == 25) press_keys(1'b1, 1'b0);
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL pre_reset cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
        @(posedge clk); #3;
        key_run = 1'b1;
        rst_n   = 1'b0;
        #1;
        n_cmp++;
        if (dut_out !== {9'h03F, 9'h03F, 1'b0}) begin
            n_bad++; $display("FAIL async_reset got=%h exp=%h", dut_out, {9'h03F, 9'h03F, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); n_cmp++;
            if (dut_out !== exp_out) begin n_bad++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, dut_out, exp_out); end
        end
        n_cmp++;
        if (running !== 1'b0) begin n_bad++; $display("FAIL lost_press got=%b exp=0", running); end
    endtask

    initial begin
        test_reset();
        test_run_up();
        test_up_wrap();
        test_down_wrap();
        test_bounce();
        test_clear_tick();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
